// File: rtl/load_ext_ctrl_if.sv
// Bundles the load-issue, memory read-data and write-back signals of load_ext_ctrl.
interface load_ext_ctrl_if #(
    parameter int unsigned RD_W = 5
) ();
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_type;
    logic [1:0]      req_addr_lo;
    logic [RD_W-1:0] req_rd;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic            flush;
    logic            wb_valid;
    logic [31:0]     wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            err_orphan;
    logic            adel;
    logic [RD_W-1:0] adel_rd;

    modport master (
        output req_valid, req_type, req_addr_lo, req_rd, mem_rvalid, mem_rdata, flush,
        input  req_ready, wb_valid, wb_data, wb_rd, err_orphan, adel, adel_rd
    );

    modport slave (
        input  req_valid, req_type, req_addr_lo, req_rd, mem_rvalid, mem_rdata, flush,
        output req_ready, wb_valid, wb_data, wb_rd, err_orphan, adel, adel_rd
    );
endinterface

// File: rtl/load_ext_ctrl.sv
// In-order load tracking queue with byte/half/word sign/zero extension for write-back.
// Optional misaligned-load trap enabled by defining LOAD_EXT_ALIGN_TRAP_EN.
module load_ext_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RD_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    load_ext_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [2:0]      typ;
        logic [1:0]      addr_lo;
        logic [RD_W-1:0] rd;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [DEPTH-1:0]  discard_q, discard_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              err_orphan_q, err_orphan_d;

    logic              full_c, empty_c, accept_c, push_c, pop_c, misalign_c;
    logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
    entry_t            head_c;

    function automatic logic [31:0] extend(input entry_t e, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sx;
        sx = ~e.typ[2];
        case (e.addr_lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = e.addr_lo[1] ? w[31:16] : w[15:0];
        case (e.typ[1:0])
            2'b00:   extend = {{24{b[7] & sx}}, b};
            2'b01:   extend = {{16{h[15] & sx}}, h};
            default: extend = w;
        endcase
    endfunction

    // Full uses the count; empty compares the extra-bit pointers.
    assign full_c        = (count_q == PTR_W'(DEPTH));
    assign empty_c       = (wr_ptr_q == rd_ptr_q);
    assign bus.req_ready = ~full_c & ~bus.flush;
    assign accept_c      = bus.req_valid & bus.req_ready;
    assign wr_idx_c      = wr_ptr_q[IDX_W-1:0];
    assign rd_idx_c      = rd_ptr_q[IDX_W-1:0];
    assign head_c        = ent_q[rd_idx_c];

`ifdef LOAD_EXT_ALIGN_TRAP_EN
    logic            adel_q, adel_d;
    logic [RD_W-1:0] adel_rd_q, adel_rd_d;

    always_comb begin
        misalign_c = 1'b0;
        case (bus.req_type)
            3'b000, 3'b100: misalign_c = 1'b0;
            3'b001, 3'b101: misalign_c = bus.req_addr_lo[0];
            default:        misalign_c = (bus.req_addr_lo != 2'b00);
        endcase
        adel_d    = accept_c & misalign_c;
        adel_rd_d = adel_d ? bus.req_rd : adel_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q    <= 1'b0;
            adel_rd_q <= '0;
        end else begin
            adel_q    <= adel_d;
            adel_rd_q <= adel_rd_d;
        end
    end

    assign bus.adel    = adel_q;
    assign bus.adel_rd = adel_rd_q;
`else
    assign misalign_c  = 1'b0;
    assign bus.adel    = 1'b0;
    assign bus.adel_rd = '0;
`endif

    assign push_c = accept_c & ~misalign_c;
    assign pop_c  = bus.mem_rvalid & ~empty_c;

    always_comb begin
        ent_d        = ent_q;
        discard_d    = discard_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        err_orphan_d = err_orphan_q | (bus.mem_rvalid & empty_c);

        // Flush marks every slot; push cannot coincide since req_ready is low.
        if (bus.flush) discard_d = '1;

        if (push_c) begin
            ent_d[wr_idx_c]     = '{typ: bus.req_type, addr_lo: bus.req_addr_lo, rd: bus.req_rd};
            discard_d[wr_idx_c] = 1'b0;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (~discard_q[rd_idx_c] & ~bus.flush) begin
                wb_valid_d = 1'b1;
                wb_data_d  = extend(head_c, bus.mem_rdata);
                wb_rd_d    = head_c.rd;
            end
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            discard_q    <= discard_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.err_orphan = err_orphan_q;
endmodule

// File: tb/tb_load_ext_ctrl.sv
// Scoreboard bench for load_ext_ctrl: queue-based reference model plus decoupled output monitor.
module tb_load_ext_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RD_W  = 5;
`ifdef LOAD_EXT_ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [2:0] T_LB = 3'b000, T_LH = 3'b001, T_LW = 3'b010,
                           T_LBU = 3'b100, T_LHU = 3'b101;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_ext_ctrl_if #(.RD_W(RD_W)) bus ();
    load_ext_ctrl #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]      t;
        logic [1:0]      a;
        logic [RD_W-1:0] rd;
        bit              disc;
    } mentry_t;

    typedef struct {
        int              cyc;
        logic [31:0]     data;
        logic [RD_W-1:0] rd;
    } wb_exp_t;

    mentry_t         mq[$];
    wb_exp_t         eq[$];
    bit              orphan_m = 1'b0;
    int              adel_cyc = -1;
    logic [RD_W-1:0] adel_rd_m = '0;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference extension by arithmetic on the selected field value.
    function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [1:0] a,
                                            input logic [31:0] w);
        int unsigned size, off;
        logic [31:0] v, lim;
        bit sgn;
        sgn = (t == T_LB) || (t == T_LH);
        if (t == T_LB || t == T_LBU)      size = 1;
        else if (t == T_LH || t == T_LHU) size = 2;
        else                              size = 4;
        if (size == 4) return w;
        off = (size == 1) ? int'(a) : int'(a) & 2;
        v   = (w >> (8 * off)) & ((32'd1 << (8 * size)) - 32'd1);
        lim = 32'd1 << (8 * size - 1);
        if (sgn && v >= lim) v = v - (32'd1 << (8 * size));
        return v;
    endfunction

    function automatic bit ref_mis(input logic [2:0] t, input logic [1:0] a);
        if (t == T_LH || t == T_LHU) return a[0];
        if (t == T_LB || t == T_LBU) return 1'b0;
        return a != 2'b00;
    endfunction

    task automatic step(input bit v, input logic [2:0] t, input logic [1:0] a,
                        input logic [RD_W-1:0] rd, input bit mv, input logic [31:0] md,
                        input bit fl);
        bit      rdy;
        mentry_t e;
        wb_exp_t x;
        @(negedge clk);
        rst             = 1'b0;
        bus.req_valid   = v;
        bus.req_type    = t;
        bus.req_addr_lo = a;
        bus.req_rd      = rd;
        bus.mem_rvalid  = mv;
        bus.mem_rdata   = md;
        bus.flush       = fl;
        #1;
        rdy = (mq.size() != DEPTH) && !fl;
        chk("req_ready", bus.req_ready, rdy);
        if (mv) begin
            if (mq.size() == 0) orphan_m = 1'b1;
            else begin
                e = mq.pop_front();
                if (!e.disc && !fl) begin
                    x.cyc = cyc + 1; x.data = ref_ext(e.t, e.a, md); x.rd = e.rd;
                    eq.push_back(x);
                end
            end
        end
        if (fl) foreach (mq[i]) mq[i].disc = 1'b1;
        if (v && rdy) begin
            if (TRAP && ref_mis(t, a)) begin
                adel_cyc = cyc + 1; adel_rd_m = rd;
            end else begin
                e.t = t; e.a = a; e.rd = rd; e.disc = 1'b0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, T_LW, 2'd0, '0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.mem_rvalid = 1'b0; bus.flush = 1'b0;
        mq.delete(); eq.delete(); orphan_m = 1'b0; adel_cyc = -1;
        @(posedge clk);
        #2;
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_err_orphan", bus.err_orphan, 0);
        chk("rst_adel", bus.adel, 0);
        chk("rst_adel_rd", bus.adel_rd, 0);
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    initial begin
        bit      exp_v;
        wb_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (eq.size() > 0 && eq[0].cyc < cyc) void'(eq.pop_front());
            exp_v = (eq.size() > 0) && (eq[0].cyc == cyc);
            chk("wb_valid", bus.wb_valid, exp_v);
            if (exp_v) begin
                e = eq.pop_front();
                if (bus.wb_valid === 1'b1) begin
                    chk("wb_data", bus.wb_data, e.data);
                    chk("wb_rd", bus.wb_rd, e.rd);
                end
            end
            chk("err_orphan", bus.err_orphan, orphan_m);
            chk("adel", bus.adel, adel_cyc == cyc);
            if (adel_cyc == cyc) chk("adel_rd", bus.adel_rd, adel_rd_m);
        end
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_type = T_LW; bus.req_addr_lo = 2'd0; bus.req_rd = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.flush = 1'b0;
        do_reset();

        // Byte and half extension
        step(1'b1, T_LB, 2'd2, 5'd5, 1'b0, 32'h0, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'h1280_3456, 1'b0);
        step(1'b1, T_LHU, 2'd2, 5'd7, 1'b0, 32'h0, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'hBEEF_1234, 1'b0);
        step(1'b1, T_LH, 2'd2, 5'd7, 1'b0, 32'h0, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'hBEEF_1234, 1'b0);
        idle();

        // Fill, blocked push during pop, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, T_LW, 2'd0, RD_W'(i), 1'b0, 32'h0, 1'b0);
        step(1'b1, T_LW, 2'd0, 5'd8, 1'b0, 32'h0, 1'b0);
        step(1'b1, T_LW, 2'd0, 5'd8, 1'b1, 32'hAAAA_0001, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'hBBBB_0002, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'hCCCC_0003, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'hDDDD_0004, 1'b0);
        idle();

        // Flush discards outstanding loads only
        step(1'b1, T_LW, 2'd0, 5'd3, 1'b0, 32'h0, 1'b0);
        step(1'b1, T_LW, 2'd0, 5'd4, 1'b0, 32'h0, 1'b0);
        step(1'b1, T_LW, 2'd0, 5'd10, 1'b0, 32'h0, 1'b1);
        step(1'b1, T_LW, 2'd0, 5'd9, 1'b0, 32'h0, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'h1111_1111, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'h2222_2222, 1'b0);
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'h3333_3333, 1'b0);
        idle();

        // Orphan beat, sticky until reset
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle(); idle();
        do_reset();

        // Misaligned half: trapped or enqueued depending on build
        step(1'b1, T_LH, 2'd1, 5'd6, 1'b0, 32'h0, 1'b0);
        idle();
        step(1'b0, T_LW, 2'd0, 5'd0, 1'b1, 32'h1234_8001, 1'b0);
        idle();
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit mv;
            if (i % 150 == 149) do_reset();
            mv = (mq.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 20 == 0);
            step($urandom % 2 == 0, 3'($urandom % 8), 2'($urandom % 4), RD_W'($urandom),
                 mv, $urandom, $urandom % 12 == 0);
        end
        for (int i = 0; i < 3; i++) idle();
        chk("scoreboard_drained", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
